rs_issue_queue: RTL and testbench
=================================

Name: rs_issue_queue

Overview:
- Parametrised successor to the 4-entry reservation station. Holds dispatched instructions until both source operands are resolved, snooping NCDB common-data-bus ports.
- Issues the oldest ready entry to a functional unit over a valid/ready handshake, with backpressure.
- Adds three things the 4-entry station lacks: age-ordered select, insert-time CDB bypass and flush.
- Sits between dispatch/rename and one functional-unit pipeline.

Parameters:
- DEPTH, 8, number of entries (power of 2, >=2)
- TAG_W, 4, ROB index width
- DATA_W, 16, operand width
- OPC_W, 4, opcode width
- IMM_W, 8, immediate width
- NCDB, 4, number of CDB ports

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  sync squash of all entries and the output register
- in_valid  in  1  dispatch request
- in_ready  out  1  free entry exists
- in_tag  in  TAG_W  ROB index of instruction
- in_opcode  in  OPC_W  opcode
- in_imm  in  IMM_W  immediate
- in_src1_tag, in_src2_tag  in  TAG_W  producer ROB index per source
- in_src1_val, in_src2_val  in  DATA_W  source value when ready
- in_src1_rdy, in_src2_rdy  in  1  source already resolved (single-operand ops: src2_rdy=1)
- cdb_valid  in  NCDB  per-port broadcast valid, bit k = port k
- cdb_tag  in  NCDB*TAG_W  port k at [k*TAG_W +: TAG_W]
- cdb_data  in  NCDB*DATA_W  port k at [k*DATA_W +: DATA_W]
- out_valid  out  1  issue register holds an instruction
- out_ready  in  1  functional unit accepts
- out_tag, out_opcode, out_imm, out_val1, out_val2  out  TAG_W/OPC_W/IMM_W/DATA_W/DATA_W  issued fields
- free_count  out  $clog2(DEPTH)+1  number of empty entries

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
  - On reset: all entry valid bits=0, age matrix=0, out_valid=0, free_count=DEPTH, in_ready=1.
  - Payload registers are don't-care after reset.
- Insert:
  - Accept on in_valid & in_ready. in_ready = (free_count != 0) and is computed from registered state only; an issue in the same cycle does not create space.
  - Target is the lowest-index empty entry. The new entry is marked younger than every valid entry.
  - in_valid while !in_ready: input ignored, no state change.
- Wakeup:
  - Each cycle, every valid entry with an unresolved source compares its tag against all NCDB ports.
  - On a match, capture that port's data and set rdy. If several ports match, the lowest k wins.
  - src1 and src2 wake independently, including in the same cycle from different ports.
- Insert-time bypass: for an accepted insert with src rdy=0, the CDB is checked that same cycle. On a match, the entry is written with rdy=1 and the CDB data.
- Select/issue:
  - Candidates are entries that are valid with both rdy=1 in registered state. The oldest candidate is chosen via the age matrix.
  - The transfer happens when (!out_valid | out_ready): the chosen entry moves to the output register, out_valid=1, and the entry is freed at the same edge.
  - If no candidate exists and out_ready=1, out_valid goes to 0.
  - If out_valid & !out_ready, the output register holds stable and no entry is freed.
- Latency:
  - Insert with both sources ready at edge E → out_valid after edge E+1, given no older candidate and no backpressure.
  - CDB wakeup at edge E → eligible to issue at edge E+1.
  - Minimum dispatch-to-issue is 2 cycles.
- Simultaneous events:
  - Insert and issue in one cycle: both happen, free_count unchanged.
  - Insert into an entry that becomes free this cycle is not allowed; this follows from in_ready being registered.
- Flush:
  - Synchronous, and has priority over insert, wakeup and issue.
  - Next cycle: all entries invalid, out_valid=0, age matrix cleared, free_count=DEPTH.
- Reset mid-operation: immediate clear as above. No partial issue.
- Wakeup compares unresolved sources only; a resolved source is never overwritten.
- Tags are not checked for uniqueness. Dispatch guarantees distinct in-flight tags.

Decomposition:
- Shared package rs_pkg holds:
  - the entry struct typedef (valid, tag, opcode, imm, src tags/vals/rdy)
  - a CDB port struct typedef
  - default width constants matching the parameters
- One sub-module, rs_age_picker. It is a DEPTH×DEPTH age matrix with set-on-allocate, clear-on-free and clear-all. Given a request vector it outputs a one-hot grant for the oldest requester, plus a grant-valid.

Test Plan:
- Reset/idle: assert rst mid-run with 3 entries → out_valid=0, free_count=8, in_ready=1 immediately, independent of clk.
- Ready-at-dispatch: insert tag=3, opc=2, val1=0x0011, val2=0x0022, both rdy, out_ready=1 → two edges later out_valid=1, out_tag=3, out_val1=0x0011, out_val2=0x0022.
- Wakeup and port priority: insert tag=5, src1_tag=9 not ready. Next cycle cdb_valid=4'b0110, port1 tag=9 data=0xAAAA, port2 tag=9 data=0xBBBB → issues with out_val1=0xAAAA.
- Age order: insert tags 1, 2, 3 all waiting on producer 7, then broadcast 7 once → issue order 1, 2, 3 on consecutive cycles.
- Full/backpressure: fill 8 entries, all ready, out_ready=0 → in_ready=0, out_tag held stable. Raise out_ready → one issue per cycle, free_count rising 1…8.
- Bypass and flush: insert with src2_tag=4 while the same-cycle CDB broadcasts tag 4 = 0x1234 → issues with val2=0x1234. Then pulse flush with 2 pending entries → out_valid=0 and free_count=8 next cycle.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types and default widths for the reservation-station issue queue.
// Holds the default parameter values, the entry record layout and the CDB
// broadcast record layout used at the default widths.
package rs_pkg;

  localparam int unsigned RS_DEPTH  = 8;
  localparam int unsigned RS_TAG_W  = 4;
  localparam int unsigned RS_DATA_W = 16;
  localparam int unsigned RS_OPC_W  = 4;
  localparam int unsigned RS_IMM_W  = 8;
  localparam int unsigned RS_NCDB   = 4;

  // One reservation-station slot at the default widths.
  typedef struct packed {
    logic                 valid;
    logic [RS_TAG_W-1:0]  tag;
    logic [RS_OPC_W-1:0]  opcode;
    logic [RS_IMM_W-1:0]  imm;
    logic [RS_TAG_W-1:0]  src1_tag;
    logic [RS_DATA_W-1:0] src1_val;
    logic                 src1_rdy;
    logic [RS_TAG_W-1:0]  src2_tag;
    logic [RS_DATA_W-1:0] src2_val;
    logic                 src2_rdy;
  } rs_entry_t;

  // One common-data-bus broadcast port.
  typedef struct packed {
    logic                 valid;
    logic [RS_TAG_W-1:0]  tag;
    logic [RS_DATA_W-1:0] data;
  } rs_cdb_t;

endpackage

// File: rtl/rs_age_picker.sv
// Age-matrix oldest-first picker.
// age_q[i][j] = 1 means entry i is older than entry j.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clr_all        clear the whole matrix (flush)
//   occ            entries occupied in registered state
//   alloc_oh       one-hot entry allocated this cycle (or zero)
//   free_oh        entries freed this cycle
//   req            requesting entries
//   grant_oh_c     one-hot grant of the oldest requester (combinational)
//   grant_vld_c    some requester exists (combinational)
module rs_age_picker
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH = RS_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_all,
  input  logic [DEPTH-1:0] occ,
  input  logic [DEPTH-1:0] alloc_oh,
  input  logic [DEPTH-1:0] free_oh,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant_oh_c,
  output logic             grant_vld_c
);

  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
  logic [DEPTH-1:0] blk;

  // Matrix update: allocate makes the new entry younger than all occupants,
  // free clears the row/column, clear-all wins over both.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) age_d[i] = age_q[i];
    for (int a = 0; a < int'(DEPTH); a++) begin
      if (alloc_oh[a]) begin
        for (int j = 0; j < int'(DEPTH); j++) begin
          age_d[a][j] = 1'b0;
          age_d[j][a] = occ[j];
        end
      end
    end
    for (int f = 0; f < int'(DEPTH); f++) begin
      if (free_oh[f]) begin
        for (int j = 0; j < int'(DEPTH); j++) begin
          age_d[f][j] = 1'b0;
          age_d[j][f] = 1'b0;
        end
      end
    end
    if (clr_all) begin
      for (int i = 0; i < int'(DEPTH); i++) age_d[i] = '0;
    end
  end

  // A requester is blocked if any other requester is older than it.
  always_comb begin
    blk = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (req[j] && age_q[j][i]) blk[i] = 1'b1;
      end
    end
    grant_oh_c  = req & ~blk;
    grant_vld_c = |req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) age_q[i] <= age_d[i];
    end
  end

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation-station issue queue: holds dispatched instructions until both
// sources resolve (CDB snoop, including same-cycle bypass at insert), then
// issues the oldest ready entry through a registered valid/ready output.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   flush               synchronous squash of all entries and output register
//   in_*                dispatch request (valid/ready) and instruction fields
//   cdb_valid/tag/data  NCDB broadcast ports, port k in slice k
//   out_*               issue register (valid/ready) and issued fields
//   free_count          number of empty entries
module rs_issue_queue
  import rs_pkg::*;
#(
  parameter int unsigned DEPTH  = RS_DEPTH,
  parameter int unsigned TAG_W  = RS_TAG_W,
  parameter int unsigned DATA_W = RS_DATA_W,
  parameter int unsigned OPC_W  = RS_OPC_W,
  parameter int unsigned IMM_W  = RS_IMM_W,
  parameter int unsigned NCDB   = RS_NCDB
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [OPC_W-1:0]       in_opcode,
  input  logic [IMM_W-1:0]       in_imm,
  input  logic [TAG_W-1:0]       in_src1_tag,
  input  logic [TAG_W-1:0]       in_src2_tag,
  input  logic [DATA_W-1:0]      in_src1_val,
  input  logic [DATA_W-1:0]      in_src2_val,
  input  logic                   in_src1_rdy,
  input  logic                   in_src2_rdy,
  input  logic [NCDB-1:0]        cdb_valid,
  input  logic [NCDB*TAG_W-1:0]  cdb_tag,
  input  logic [NCDB*DATA_W-1:0] cdb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TAG_W-1:0]       out_tag,
  output logic [OPC_W-1:0]       out_opcode,
  output logic [IMM_W-1:0]       out_imm,
  output logic [DATA_W-1:0]      out_val1,
  output logic [DATA_W-1:0]      out_val2,
  output logic [$clog2(DEPTH):0] free_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [OPC_W-1:0]  opcode;
    logic [IMM_W-1:0]  imm;
    logic [TAG_W-1:0]  s1_tag;
    logic [DATA_W-1:0] s1_val;
    logic              s1_rdy;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W-1:0] s2_val;
    logic              s2_rdy;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  ent_t             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] free_count_q, free_count_d;

  logic             accept;
  logic [IDX_W-1:0] alloc_idx;
  logic [DEPTH-1:0] alloc_oh;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] grant_oh;
  logic             grant_vld;
  logic             xfer;
  logic [DEPTH-1:0] free_oh;
  ent_t             sel_e;
  ent_t             new_e;
  logic [DATA_W:0]  m1, m2, b1, b2;

  // Lowest-index matching CDB port: returns {hit, data}.
  function automatic logic [DATA_W:0] cdb_match(
    input logic [TAG_W-1:0]       t,
    input logic [NCDB-1:0]        v,
    input logic [NCDB*TAG_W-1:0]  tg,
    input logic [NCDB*DATA_W-1:0] dt
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int k = int'(NCDB) - 1; k >= 0; k--) begin
      if (v[k] && (tg[k*TAG_W +: TAG_W] == t)) r = {1'b1, dt[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  assign accept = in_valid & in_ready_q;
  assign xfer   = ~out_valid_q | out_ready;

  // Allocation target: lowest empty entry in registered state.
  always_comb begin
    alloc_idx = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
    end
    alloc_oh = accept ? (DEPTH'(1) << alloc_idx) : '0;
  end

  // Issue candidates come from registered state only.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      cand[i] = valid_q[i] & ent_q[i].s1_rdy & ent_q[i].s2_rdy;
    end
  end

  rs_age_picker #(.DEPTH(DEPTH)) u_age (
    .clk        (clk),
    .rst        (rst),
    .clr_all    (flush),
    .occ        (valid_q),
    .alloc_oh   (alloc_oh),
    .free_oh    (free_oh),
    .req        (cand),
    .grant_oh_c (grant_oh),
    .grant_vld_c(grant_vld)
  );

  assign free_oh = (xfer && grant_vld) ? grant_oh : '0;

  // One-hot mux of the granted entry.
  always_comb begin
    sel_e = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (grant_oh[i]) sel_e = ent_q[i];
    end
  end

  // New entry with same-cycle CDB bypass for unresolved sources.
  always_comb begin
    b1 = cdb_match(in_src1_tag, cdb_valid, cdb_tag, cdb_data);
    b2 = cdb_match(in_src2_tag, cdb_valid, cdb_tag, cdb_data);
    new_e        = '0;
    new_e.tag    = in_tag;
    new_e.opcode = in_opcode;
    new_e.imm    = in_imm;
    new_e.s1_tag = in_src1_tag;
    new_e.s2_tag = in_src2_tag;
    if (in_src1_rdy) begin
      new_e.s1_rdy = 1'b1;
      new_e.s1_val = in_src1_val;
    end else begin
      new_e.s1_rdy = b1[DATA_W];
      new_e.s1_val = b1[DATA_W] ? b1[DATA_W-1:0] : in_src1_val;
    end
    if (in_src2_rdy) begin
      new_e.s2_rdy = 1'b1;
      new_e.s2_val = in_src2_val;
    end else begin
      new_e.s2_rdy = b2[DATA_W];
      new_e.s2_val = b2[DATA_W] ? b2[DATA_W-1:0] : in_src2_val;
    end
  end

  // Next state: wakeup, issue, insert, then flush overriding all.
  always_comb begin
    valid_d     = valid_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    m1          = '0;
    m2          = '0;
    for (int i = 0; i < int'(DEPTH); i++) ent_d[i] = ent_q[i];

    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid_q[i]) begin
        if (!ent_q[i].s1_rdy) begin
          m1 = cdb_match(ent_q[i].s1_tag, cdb_valid, cdb_tag, cdb_data);
          if (m1[DATA_W]) begin
            ent_d[i].s1_rdy = 1'b1;
            ent_d[i].s1_val = m1[DATA_W-1:0];
          end
        end
        if (!ent_q[i].s2_rdy) begin
          m2 = cdb_match(ent_q[i].s2_tag, cdb_valid, cdb_tag, cdb_data);
          if (m2[DATA_W]) begin
            ent_d[i].s2_rdy = 1'b1;
            ent_d[i].s2_val = m2[DATA_W-1:0];
          end
        end
      end
    end

    valid_d = valid_d & ~free_oh;
    if (xfer) begin
      out_valid_d = grant_vld;
      if (grant_vld) out_d = sel_e;
    end

    if (accept) begin
      valid_d[alloc_idx] = 1'b1;
      ent_d[alloc_idx]   = new_e;
    end

    if (flush) begin
      valid_d     = '0;
      out_valid_d = 1'b0;
    end
  end

  // Empty-entry count and dispatch-ready, registered for next cycle.
  always_comb begin
    free_count_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (!valid_d[i]) free_count_d = free_count_d + CNT_W'(1);
    end
    in_ready_d = (free_count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      free_count_q <= CNT_W'(DEPTH);
    end else begin
      valid_q      <= valid_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      free_count_q <= free_count_d;
    end
  end

  // Payload storage needs no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= ent_d[i];
    out_q <= out_d;
  end

  assign in_ready   = in_ready_q;
  assign free_count = free_count_q;
  assign out_valid  = out_valid_q;
  assign out_tag    = out_q.tag;
  assign out_opcode = out_q.opcode;
  assign out_imm    = out_q.imm;
  assign out_val1   = out_q.s1_val;
  assign out_val2   = out_q.s2_val;

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue with an in-order issue scoreboard.
module tb_rs_issue_queue;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned IMM_W  = 8;
  localparam int unsigned NCDB   = 4;
  localparam int unsigned CNT_W  = 4;

  logic                   clk;
  logic                   rst;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [TAG_W-1:0]       in_tag;
  logic [OPC_W-1:0]       in_opcode;
  logic [IMM_W-1:0]       in_imm;
  logic [TAG_W-1:0]       in_src1_tag, in_src2_tag;
  logic [DATA_W-1:0]      in_src1_val, in_src2_val;
  logic                   in_src1_rdy, in_src2_rdy;
  logic [NCDB-1:0]        cdb_valid;
  logic [NCDB*TAG_W-1:0]  cdb_tag;
  logic [NCDB*DATA_W-1:0] cdb_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [TAG_W-1:0]       out_tag;
  logic [OPC_W-1:0]       out_opcode;
  logic [IMM_W-1:0]       out_imm;
  logic [DATA_W-1:0]      out_val1, out_val2;
  logic [CNT_W-1:0]       free_count;

  rs_issue_queue #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W),
    .OPC_W(OPC_W), .IMM_W(IMM_W), .NCDB(NCDB)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag),
    .in_opcode(in_opcode), .in_imm(in_imm),
    .in_src1_tag(in_src1_tag), .in_src2_tag(in_src2_tag),
    .in_src1_val(in_src1_val), .in_src2_val(in_src2_val),
    .in_src1_rdy(in_src1_rdy), .in_src2_rdy(in_src2_rdy),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_opcode(out_opcode), .out_imm(out_imm),
    .out_val1(out_val1), .out_val2(out_val2), .free_count(free_count)
  );

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [OPC_W-1:0]  opc;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Sample just before the edge (scoreboard on handshake), then step past it.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      n_assert++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected observed tag=%0h expected no issue", out_tag);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_tag",  32'(out_tag),    32'(e.tag));
        chk("sb_opc",  32'(out_opcode), 32'(e.opc));
        chk("sb_imm",  32'(out_imm),    32'(e.imm));
        chk("sb_val1", 32'(out_val1),   32'(e.v1));
        chk("sb_val2", 32'(out_val2),   32'(e.v2));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Drive one dispatch for a cycle; optionally record its expected issue.
  task automatic ins(input logic [TAG_W-1:0] tag, input logic [OPC_W-1:0] opc,
                     input logic [TAG_W-1:0] s1t, input logic [DATA_W-1:0] s1v, input logic s1r,
                     input logic [TAG_W-1:0] s2t, input logic [DATA_W-1:0] s2v, input logic s2r,
                     input logic push, input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2);
    exp_t e;
    in_valid    = 1'b1;
    in_tag      = tag;
    in_opcode   = opc;
    in_imm      = {4'h5, tag};
    in_src1_tag = s1t; in_src1_val = s1v; in_src1_rdy = s1r;
    in_src2_tag = s2t; in_src2_val = s2v; in_src2_rdy = s2r;
    if (push) begin
      e.tag = tag; e.opc = opc; e.imm = {4'h5, tag}; e.v1 = e1; e.v2 = e2;
      sb.push_back(e);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic cdb_set(input int k, input logic v, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_valid[k] = v;
    cdb_tag[k*TAG_W +: TAG_W]    = t;
    cdb_data[k*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_tag = '0; in_opcode = '0; in_imm = '0;
    in_src1_tag = '0; in_src2_tag = '0; in_src1_val = '0; in_src2_val = '0;
    in_src1_rdy = 1'b0; in_src2_rdy = 1'b0;
    cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    tick(); tick();
    chk("rst_out_valid",  32'(out_valid),  32'(0));
    chk("rst_free_count", 32'(free_count), 32'(8));
    chk("rst_in_ready",   32'(in_ready),   32'(1));
    rst = 1'b0;
    tick();

    // Ready at dispatch: issue register loads one edge after the insert edge.
    ins(4'd3, 4'd2, 4'd0, 16'h0011, 1'b1, 4'd0, 16'h0022, 1'b1, 1'b1, 16'h0011, 16'h0022);
    chk("rad_not_yet", 32'(out_valid),  32'(0));
    chk("rad_free7",   32'(free_count), 32'(7));
    tick();
    chk("rad_valid", 32'(out_valid), 32'(1));
    chk("rad_tag",   32'(out_tag),   32'(3));
    chk("rad_val1",  32'(out_val1),  32'(16'h0011));
    chk("rad_val2",  32'(out_val2),  32'(16'h0022));
    tick();

    // Wakeup with two matching ports: port 1 wins; invalid port 0 ignored.
    ins(4'd5, 4'd1, 4'd9, 16'h0000, 1'b0, 4'd0, 16'h0505, 1'b1, 1'b1, 16'hAAAA, 16'h0505);
    cdb_set(0, 1'b0, 4'd9, 16'hCCCC);
    cdb_set(1, 1'b1, 4'd9, 16'hAAAA);
    cdb_set(2, 1'b1, 4'd9, 16'hBBBB);
    cdb_set(3, 1'b0, 4'd9, 16'hDDDD);
    tick();
    cdb_valid = '0;
    chk("wk_not_yet", 32'(out_valid), 32'(0));
    tick();
    chk("wk_valid", 32'(out_valid), 32'(1));
    chk("wk_val1",  32'(out_val1),  32'(16'hAAAA));
    tick();

    // Age order with reused low entry: oldest (tag 1) sits at a higher index.
    ins(4'd12, 4'd3, 4'd14, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 1'b1, 16'h1414, 16'h0000);
    ins(4'd1,  4'd4, 4'd7,  16'h0000, 1'b0, 4'd0, 16'h0001, 1'b1, 1'b1, 16'h0707, 16'h0001);
    cdb_set(0, 1'b1, 4'd14, 16'h1414);
    tick();
    cdb_valid = '0;
    tick();
    chk("age_x_tag", 32'(out_tag), 32'(12));
    ins(4'd2, 4'd5, 4'd7, 16'h0000, 1'b0, 4'd0, 16'h0002, 1'b1, 1'b1, 16'h0707, 16'h0002);
    ins(4'd3, 4'd6, 4'd7, 16'h0000, 1'b0, 4'd0, 16'h0003, 1'b1, 1'b1, 16'h0707, 16'h0003);
    cdb_set(2, 1'b1, 4'd7, 16'h0707);
    tick();
    cdb_valid = '0;
    tick();
    chk("age_first",  32'(out_tag), 32'(1));
    tick();
    chk("age_second", 32'(out_tag), 32'(2));
    tick();
    chk("age_third",  32'(out_tag), 32'(3));
    tick();

    // Full with backpressure, then drain one per cycle.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ins(4'(i), 4'(i + 1), 4'd0, 16'(16'h0100 + i), 1'b1, 4'd0, 16'(16'h0200 + i), 1'b1,
          1'b1, 16'(16'h0100 + i), 16'(16'h0200 + i));
    end
    chk("full_in_ready", 32'(in_ready),   32'(0));
    chk("full_free",     32'(free_count), 32'(0));
    chk("full_out_tag",  32'(out_tag),    32'(0));
    ins(4'd9, 4'd9, 4'd0, 16'h0909, 1'b1, 4'd0, 16'h0909, 1'b1, 1'b0, 16'h0, 16'h0);
    chk("full_ignored", 32'(free_count), 32'(0));
    tick();
    chk("full_hold_tag",   32'(out_tag),   32'(0));
    chk("full_hold_valid", 32'(out_valid), 32'(1));
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("drain_free", 32'(free_count), 32'(k));
      chk("drain_tag",  32'(out_tag),    32'(k));
    end
    tick();

    // Insert-time bypass on src2; resolved src1 with same tag stays intact.
    cdb_set(3, 1'b1, 4'd4, 16'h1234);
    ins(4'd6, 4'd7, 4'd4, 16'h0606, 1'b1, 4'd4, 16'h0000, 1'b0, 1'b1, 16'h0606, 16'h1234);
    cdb_valid = '0;
    tick();
    chk("byp_valid", 32'(out_valid), 32'(1));
    chk("byp_val2",  32'(out_val2),  32'(16'h1234));
    chk("byp_val1",  32'(out_val1),  32'(16'h0606));
    tick();

    // Flush with an occupied output register and two pending entries.
    out_ready = 1'b0;
    ins(4'd14, 4'd1, 4'd0, 16'h0E0E, 1'b1, 4'd0, 16'h0E0E, 1'b1, 1'b0, 16'h0, 16'h0);
    ins(4'd12, 4'd2, 4'd13, 16'h0000, 1'b0, 4'd0, 16'h0C0C, 1'b1, 1'b0, 16'h0, 16'h0);
    ins(4'd10, 4'd3, 4'd13, 16'h0000, 1'b0, 4'd0, 16'h0A0A, 1'b1, 1'b0, 16'h0, 16'h0);
    chk("pre_flush_free",  32'(free_count), 32'(6));
    chk("pre_flush_valid", 32'(out_valid),  32'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid",    32'(out_valid),  32'(0));
    chk("flush_free",     32'(free_count), 32'(8));
    chk("flush_in_ready", 32'(in_ready),   32'(1));
    cdb_set(0, 1'b1, 4'd13, 16'h5555);
    tick();
    cdb_valid = '0;
    tick(); tick();
    chk("flush_no_issue", 32'(out_valid), 32'(0));
    out_ready = 1'b1;

    // Asynchronous reset mid-cycle with work in flight.
    out_ready = 1'b0;
    ins(4'd15, 4'd1, 4'd0, 16'h0F0F, 1'b1, 4'd0, 16'h0F0F, 1'b1, 1'b0, 16'h0, 16'h0);
    ins(4'd1, 4'd2, 4'd11, 16'h0000, 1'b0, 4'd0, 16'h0001, 1'b1, 1'b0, 16'h0, 16'h0);
    ins(4'd2, 4'd2, 4'd11, 16'h0000, 1'b0, 4'd0, 16'h0002, 1'b1, 1'b0, 16'h0, 16'h0);
    ins(4'd3, 4'd2, 4'd11, 16'h0000, 1'b0, 4'd0, 16'h0003, 1'b1, 1'b0, 16'h0, 16'h0);
    chk("prerst_free",  32'(free_count), 32'(5));
    chk("prerst_valid", 32'(out_valid),  32'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid",    32'(out_valid),  32'(0));
    chk("arst_free",     32'(free_count), 32'(8));
    chk("arst_in_ready", 32'(in_ready),   32'(1));
    tick();
    rst = 1'b0;
    cdb_set(1, 1'b1, 4'd11, 16'h1111);
    tick();
    cdb_valid = '0;
    tick(); tick();
    chk("arst_no_issue", 32'(out_valid),  32'(0));
    chk("arst_free2",    32'(free_count), 32'(8));
    out_ready = 1'b1;

    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain observed=%0d pending expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
